// File: rtl/palette_ram_fader.sv
// Run-time-writable colour palette with a 2-stage lookup pipeline and a frame-driven fade engine.
// Define PALETTE_READBACK_EN to add a 1-cycle raw CPU read port.
module palette_ram_fader #(
    parameter int INDEX_W  = 3,
    parameter int CHAN_W   = 4,
    parameter int FADE_DIV = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [INDEX_W-1:0]    wr_index_i,
    input  logic [3*CHAN_W-1:0]   wr_data_i,
    input  logic                  rd_valid_in_i,
    input  logic [INDEX_W-1:0]    rd_index_i,
    input  logic                  frame_tick_i,
    input  logic                  fade_out_req_i,
    input  logic                  fade_in_req_i,
`ifdef PALETTE_READBACK_EN
    input  logic                  cpu_rd_en_i,
    input  logic [INDEX_W-1:0]    cpu_rd_index_i,
    output logic [3*CHAN_W-1:0]   cpu_rd_data_o,
    output logic                  cpu_rd_valid_o,
`endif
    output logic [CHAN_W-1:0]     red_o,
    output logic [CHAN_W-1:0]     green_o,
    output logic [CHAN_W-1:0]     blue_o,
    output logic                  rd_valid_out_o,
    output logic [CHAN_W-1:0]     fade_level_o,
    output logic                  fade_busy_o,
    output logic                  fade_done_o
);

    localparam int                DEPTH     = 2 ** INDEX_W;
    localparam int                ENTRY_W   = 3 * CHAN_W;
    localparam int                DIV_W     = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(FADE_DIV - 1);
    localparam logic [CHAN_W-1:0] LEVEL_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        DARK     = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_e;

    function automatic logic [CHAN_W-1:0] attenuate(input logic [CHAN_W-1:0] c,
                                                    input logic [CHAN_W-1:0] level);
        return (c > level) ? c - level : '0;
    endfunction

    // ------------------------------------------------------------------
    // Palette storage
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // NOTE: the palette must read back as zero after reset, so every entry is
    // reset explicitly; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en_i) begin
            mem_q[wr_index_i] <= wr_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Lookup pipeline
    // ------------------------------------------------------------------
    logic               s1_valid_q;
    logic [INDEX_W-1:0] s1_index_q;
    logic [ENTRY_W-1:0] s2_entry;
    logic [ENTRY_W-1:0] rgb_d, rgb_q;
    logic               rd_valid_q;
    logic [CHAN_W-1:0]  level_q, level_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_index_q <= '0;
        end else begin
            s1_valid_q <= rd_valid_in_i;
            s1_index_q <= rd_index_i;
        end
    end

    // Same-cycle write to the entry being read wins (write-first bypass).
    assign s2_entry = (wr_en_i && (wr_index_i == s1_index_q)) ? wr_data_i : mem_q[s1_index_q];

    always_comb begin
        rgb_d = {attenuate(s2_entry[3*CHAN_W-1:2*CHAN_W], level_q),
                 attenuate(s2_entry[2*CHAN_W-1:CHAN_W],   level_q),
                 attenuate(s2_entry[CHAN_W-1:0],          level_q)};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rgb_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= s1_valid_q;
            if (s1_valid_q) rgb_q <= rgb_d;
        end
    end

    assign red_o          = rgb_q[3*CHAN_W-1:2*CHAN_W];
    assign green_o        = rgb_q[2*CHAN_W-1:CHAN_W];
    assign blue_o         = rgb_q[CHAN_W-1:0];
    assign rd_valid_out_o = rd_valid_q;

    // ------------------------------------------------------------------
    // Fade engine
    // ------------------------------------------------------------------
    fade_state_e       state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              done_q, done_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            level_q <= '0;
            div_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        div_d   = div_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                level_d = '0;
                if (fade_out_req_i) begin
                    state_d = FADE_OUT;
                    div_d   = '0;
                end
            end
            FADE_OUT: begin
                if (frame_tick_i) begin
                    if (div_q == DIV_LAST) begin
                        div_d   = '0;
                        level_d = level_q + CHAN_W'(1);
                        if (level_q == LEVEL_MAX - CHAN_W'(1)) begin
                            state_d = DARK;
                            done_d  = 1'b1;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            DARK: begin
                level_d = LEVEL_MAX;
                if (fade_in_req_i) begin
                    state_d = FADE_IN;
                    div_d   = '0;
                end
            end
            FADE_IN: begin
                if (frame_tick_i) begin
                    if (div_q == DIV_LAST) begin
                        div_d   = '0;
                        level_d = level_q - CHAN_W'(1);
                        if (level_q == CHAN_W'(1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fade_level_o = level_q;
    assign fade_busy_o  = (state_q == FADE_OUT) || (state_q == FADE_IN);
    assign fade_done_o  = done_q;

`ifdef PALETTE_READBACK_EN
    // ------------------------------------------------------------------
    // CPU readback of raw entries, independent of the pixel pipeline
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] cpu_rd_data_q;
    logic               cpu_rd_valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpu_rd_data_q  <= '0;
            cpu_rd_valid_q <= 1'b0;
        end else begin
            cpu_rd_valid_q <= cpu_rd_en_i;
            if (cpu_rd_en_i) begin
                cpu_rd_data_q <= (wr_en_i && (wr_index_i == cpu_rd_index_i))
                               ? wr_data_i : mem_q[cpu_rd_index_i];
            end
        end
    end

    assign cpu_rd_data_o  = cpu_rd_data_q;
    assign cpu_rd_valid_o = cpu_rd_valid_q;
`endif

endmodule

// File: tb/tb_palette_ram_fader.sv
// Self-checking bench for palette_ram_fader: directed test-plan steps plus a randomized
// phase, compared against a history-based model of the palette and the fade progression.
module tb_palette_ram_fader;

    localparam int INDEX_W  = 3;
    localparam int CHAN_W   = 4;
    localparam int FADE_DIV = 2;
    localparam int DEPTH    = 2 ** INDEX_W;
    localparam int MAXL     = 2 ** CHAN_W - 1;

    localparam int M_IDLE = 0, M_OUT = 1, M_DARK = 2, M_IN = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic [INDEX_W-1:0]  wr_index;
    logic [3*CHAN_W-1:0] wr_data;
    logic                rd_valid_in;
    logic [INDEX_W-1:0]  rd_index;
    logic                frame_tick;
    logic                fade_out_req;
    logic                fade_in_req;
    logic [CHAN_W-1:0]   red, green, blue, fade_level;
    logic                rd_valid_out, fade_busy, fade_done;
`ifdef PALETTE_READBACK_EN
    logic                cpu_rd_en = 1'b0;
    logic [INDEX_W-1:0]  cpu_rd_index = '0;
    logic [3*CHAN_W-1:0] cpu_rd_data;
    logic                cpu_rd_valid;
`endif

    palette_ram_fader #(
        .INDEX_W (INDEX_W),
        .CHAN_W  (CHAN_W),
        .FADE_DIV(FADE_DIV)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .wr_en_i       (wr_en),
        .wr_index_i    (wr_index),
        .wr_data_i     (wr_data),
        .rd_valid_in_i (rd_valid_in),
        .rd_index_i    (rd_index),
        .frame_tick_i  (frame_tick),
        .fade_out_req_i(fade_out_req),
        .fade_in_req_i (fade_in_req),
`ifdef PALETTE_READBACK_EN
        .cpu_rd_en_i   (cpu_rd_en),
        .cpu_rd_index_i(cpu_rd_index),
        .cpu_rd_data_o (cpu_rd_data),
        .cpu_rd_valid_o(cpu_rd_valid),
`endif
        .red_o         (red),
        .green_o       (green),
        .blue_o        (blue),
        .rd_valid_out_o(rd_valid_out),
        .fade_level_o  (fade_level),
        .fade_busy_o   (fade_busy),
        .fade_done_o   (fade_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: palette contents, the pending lookup, and fade progress
    // expressed as ticks counted since the fade began.
    int          pal [DEPTH];
    int          m_mode;
    int          m_ticks;
    logic        p_valid;
    int          p_idx;
    logic [11:0] exp_rgb;
    logic        exp_valid;
    logic        exp_done;
    int          done_count;

    function automatic int m_level();
        case (m_mode)
            M_OUT:   return m_ticks / FADE_DIV;
            M_DARK:  return MAXL;
            M_IN:    return MAXL - m_ticks / FADE_DIV;
            default: return 0;
        endcase
    endfunction

    function automatic logic [11:0] atten(input int e, input int l);
        int r, g, b;
        r = (e >> 8) & 15;
        g = (e >> 4) & 15;
        b = e & 15;
        r = (r > l) ? r - l : 0;
        g = (g > l) ? g - l : 0;
        b = (b > l) ? b - l : 0;
        return {r[3:0], g[3:0], b[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) pal[i] = 0;
        m_mode    = M_IDLE;
        m_ticks   = 0;
        p_valid   = 1'b0;
        p_idx     = 0;
        exp_rgb   = '0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
    endtask

    task automatic clear_inputs();
        wr_en        = 1'b0;
        wr_index     = '0;
        wr_data      = '0;
        rd_valid_in  = 1'b0;
        rd_index     = '0;
        frame_tick   = 1'b0;
        fade_out_req = 1'b0;
        fade_in_req  = 1'b0;
    endtask

    // One clock cycle: update the model with this cycle's inputs, clock, then compare.
    task automatic step();
        int lvl;
        lvl = m_level();
        if (wr_en) pal[int'(wr_index)] = int'(wr_data);
        exp_valid = p_valid;
        if (p_valid) exp_rgb = atten(pal[p_idx], lvl);
        p_valid  = rd_valid_in;
        p_idx    = int'(rd_index);
        exp_done = 1'b0;
        case (m_mode)
            M_IDLE: if (fade_out_req) begin m_mode = M_OUT; m_ticks = 0; end
            M_OUT: if (frame_tick) begin
                m_ticks++;
                if (m_ticks == MAXL * FADE_DIV) begin m_mode = M_DARK; exp_done = 1'b1; end
            end
            M_DARK: if (fade_in_req) begin m_mode = M_IN; m_ticks = 0; end
            M_IN: if (frame_tick) begin
                m_ticks++;
                if (m_ticks == MAXL * FADE_DIV) begin m_mode = M_IDLE; exp_done = 1'b1; end
            end
            default: m_mode = M_IDLE;
        endcase
        @(posedge clk);
        #1;
        chk("rd_valid_out", 32'(rd_valid_out), 32'(exp_valid));
        chk("rgb", 32'({red, green, blue}), 32'(exp_rgb));
        chk("fade_level", 32'(fade_level), 32'(m_level()));
        chk("fade_busy", 32'(fade_busy), 32'((m_mode == M_OUT) || (m_mode == M_IN)));
        chk("fade_done", 32'(fade_done), 32'(exp_done));
        if (fade_done === 1'b1) done_count++;
        clear_inputs();
    endtask

    task automatic lookup(input int idx);
        rd_valid_in = 1'b1;
        rd_index    = INDEX_W'(idx);
        step();
    endtask

    task automatic write(input int idx, input logic [11:0] data);
        wr_en    = 1'b1;
        wr_index = INDEX_W'(idx);
        wr_data  = data;
        step();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        done_count = 0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_valid", 32'(rd_valid_out), 32'd0);
        chk("reset_rgb", 32'({red, green, blue}), 32'd0);
        chk("reset_level", 32'(fade_level), 32'd0);
        chk("reset_busy", 32'(fade_busy), 32'd0);
        chk("reset_done", 32'(fade_done), 32'd0);
        rst = 1'b0;

        // Write then look up with 2-cycle latency
        write(3, 12'h363);
        lookup(3);
        chk("latency_not_early", 32'(rd_valid_out), 32'd0);
        step();
        chk("first_lookup_valid", 32'(rd_valid_out), 32'd1);
        chk("first_lookup_rgb", 32'({red, green, blue}), 32'h363);

        // Back-to-back lookups, no bubbles
        write(1, 12'($urandom()));
        write(2, 12'($urandom()));
        lookup(1);
        lookup(2);
        lookup(3);
        step();
        step();

        // Write-first bypass in the stage-2 cycle
        write(5, 12'h123);
        lookup(5);
        write(5, 12'hABC);
        chk("bypass_rgb", 32'({red, green, blue}), 32'hABC);
        step();

        // Fade out over 30 ticks, looking up entry 3 on every tick
        done_count   = 0;
        fade_out_req = 1'b1;
        step();
        for (int t = 1; t <= MAXL * FADE_DIV; t++) begin
            frame_tick = 1'b1;
            lookup(3);
            step();
            if (t == 8) begin
                chk("mid_fade_level", 32'(fade_level), 32'd4);
                chk("mid_fade_rgb", 32'({red, green, blue}), 32'h020);
            end
        end
        chk("dark_level", 32'(fade_level), 32'd15);
        chk("dark_rgb", 32'({red, green, blue}), 32'h000);
        chk("fade_out_done_once", 32'(done_count), 32'd1);
        chk("dark_not_busy", 32'(fade_busy), 32'd0);

        // Both requests in DARK: only fade-in is honoured
        done_count   = 0;
        fade_out_req = 1'b1;
        fade_in_req  = 1'b1;
        step();
        chk("fade_in_busy", 32'(fade_busy), 32'd1);
        for (int t = 1; t <= MAXL * FADE_DIV; t++) begin
            frame_tick = 1'b1;
            step();
            step();
        end
        chk("fade_in_level", 32'(fade_level), 32'd0);
        chk("fade_in_done_once", 32'(done_count), 32'd1);
        chk("idle_not_busy", 32'(fade_busy), 32'd0);

        // Randomized traffic: writes, lookups, ticks and requests in any state
        for (int n = 0; n < 400; n++) begin
            wr_en        = ($urandom_range(0, 3) == 0);
            wr_index     = INDEX_W'($urandom_range(0, DEPTH - 1));
            wr_data      = 12'($urandom());
            rd_valid_in  = ($urandom_range(0, 1) == 1);
            rd_index     = INDEX_W'($urandom_range(0, DEPTH - 1));
            frame_tick   = ($urandom_range(0, 2) == 0);
            fade_out_req = ($urandom_range(0, 39) == 0);
            fade_in_req  = ($urandom_range(0, 39) == 0);
            step();
        end

        // Return to a known state, then reset mid-FADE_OUT at level 7 with a lookup in flight
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        write(3, 12'h363);
        fade_out_req = 1'b1;
        step();
        for (int k = 0; k < 100 && m_level() != 7; k++) begin
            frame_tick = 1'b1;
            step();
        end
        chk("reached_level7", 32'(fade_level), 32'd7);
        lookup(3);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_rd_valid", 32'(rd_valid_out), 32'd0);
        chk("midreset_level", 32'(fade_level), 32'd0);
        chk("midreset_busy", 32'(fade_busy), 32'd0);
        chk("midreset_rgb", 32'({red, green, blue}), 32'd0);
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        step();
        chk("after_reset_no_stale_valid", 32'(rd_valid_out), 32'd0);
        for (int i = 0; i < DEPTH; i++) lookup(i);
        step();
        step();
        chk("palette_cleared_last", 32'({red, green, blue}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/palette_ram_fader.md
Name: palette_ram_fader

Overview:
- Parametrised, run-time-writable colour palette for the sprite/background pipeline.
- Successor to the fixed per-level ROM palettes: the CPU/loader writes entries, and pixels are looked up through a 2-stage registered pipeline.
- A built-in fade engine darkens all output colours frame by frame for level transitions (fade to black, fade back in).

Parameters:
- INDEX_W, 3, palette index width; DEPTH = 2**INDEX_W entries.
- CHAN_W, 4, bits per colour channel; entry width = 3*CHAN_W, packed {red, green, blue}.
- FADE_DIV, 2, frame_tick pulses per fade step (>=1).

Ports:
- Clk  in  1  system clock, all logic rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write palette entry this cycle.
- wr_index  in  INDEX_W  entry to write.
- wr_data  in  3*CHAN_W  {red, green, blue} to write.
- rd_valid_in  in  1  pixel lookup request valid.
- rd_index  in  INDEX_W  pixel palette index.
- frame_tick  in  1  one-cycle pulse per frame (vsync edge).
- fade_out_req  in  1  start fade to black (pulse).
- fade_in_req  in  1  start fade from black (pulse).
- red, green, blue  out  CHAN_W each  faded colour of the looked-up entry.
- rd_valid_out  out  1  red/green/blue valid.
- fade_level  out  CHAN_W  current attenuation, 0 = none.
- fade_busy  out  1  high in FADE_OUT or FADE_IN.
- fade_done  out  1  one-cycle pulse on reaching DARK or IDLE from a fade.

Behaviour:
- Reset (async, any time including mid-fade or mid-lookup):
  - All palette entries = 0.
  - Pipeline valids = 0; red/green/blue = 0; rd_valid_out = 0.
  - FSM = IDLE; fade_level = 0; fade_busy = 0; fade_done = 0; frame divider = 0.
- Write: entry updated at the rising edge where wr_en = 1.
- Lookup pipeline, latency exactly 2 cycles, fully pipelined (one lookup per cycle):
  - Stage 1 registers rd_index and rd_valid_in.
  - Stage 2 reads the entry and registers the attenuated RGB plus rd_valid_out.
- Read/write ordering: the array is read in stage 2. A write committed at or before the stage-1 capture edge is visible. A write in the same cycle as the stage-2 read is bypassed (write-first: new data returned).
- Output when rd_valid_in was 0: red/green/blue hold their previous values; rd_valid_out = 0.
- Attenuation, per channel: out = saturating (c - fade_level), floored at 0, no wrap.
  - fade_level is sampled in the cycle of stage 2.
- FSM states: IDLE, FADE_OUT, DARK, FADE_IN.
  - IDLE: fade_level = 0. fade_out_req -> FADE_OUT, divider cleared. fade_in_req ignored.
  - FADE_OUT: every FADE_DIV-th frame_tick, fade_level += 1. On the step that reaches 2**CHAN_W-1 -> DARK, fade_done pulses the following cycle. All requests ignored.
  - DARK: fade_level = 2**CHAN_W-1 (all outputs 0). fade_in_req -> FADE_IN, divider cleared. fade_out_req ignored.
  - FADE_IN: every FADE_DIV-th frame_tick, fade_level -= 1. On the step that reaches 0 -> IDLE, fade_done pulses. All requests ignored.
- Simultaneous fade_out_req and fade_in_req: only the request valid in the current state is honoured.
- Divider: counts frame_tick pulses 0..FADE_DIV-1 and wraps; it steps fade_level on the wrap.
- Full fade from one end to the other takes (2**CHAN_W-1)*FADE_DIV ticks.
- Palette writes are allowed in every FSM state.

Optional Feature:
- Macro: PALETTE_READBACK_EN.
- Defined:
  - Adds inputs cpu_rd_en (1) and cpu_rd_index (INDEX_W).
  - Adds outputs cpu_rd_data (3*CHAN_W) and cpu_rd_valid (1).
  - 1-cycle registered read of the raw, unattenuated entry.
  - Independent of the pixel pipeline; same write-first bypass rule applies.
  - Reset: cpu_rd_data = 0, cpu_rd_valid = 0.
- Undefined: these ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, write idx 3 = {4'h3,4'h6,4'h3}, then lookup idx 3 -> rd_valid_out high 2 cycles later, RGB = 3,6,3, fade_level 0.
- Back-to-back lookups idx 1,2,3 on consecutive cycles -> three consecutive valid outputs in order, no bubbles.
- Write idx 5 = 0xABC in the same cycle its lookup is in stage 2 -> output 0xA,0xB,0xC (bypass).
- FADE_DIV=2, fade_out_req, then 30 frame_ticks:
  - fade_level reaches 15 after tick 30; fade_done pulses once; FSM in DARK.
  - Entry {3,6,3} reads {0,0,0}.
  - Mid-fade at level 4, the same entry reads {0,2,0}.
- In DARK, assert fade_out_req and fade_in_req together -> FADE_IN entered; 30 ticks later level 0, IDLE, fade_done pulses.
- Assert Reset mid-FADE_OUT at level 7 with a lookup in flight -> level 0, IDLE, rd_valid_out 0, palette all zero.
